// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - load/store initiator for a word-port, little-endian data memory
// Sub-word stores are read-modify-write; faults are answered without touching memory.
module data_mem_master #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [31:0] LIMIT = MEM_BYTES;

  typedef enum logic [2:0] {
    IDLE, LOAD, RMWRD, RMWR, STWR, ERR, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;

  logic [31:0] req_word;
  logic [31:0] req_last;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal_size;
  logic        req_bad;

  assign req_word     = {req_addr_i[31:2], 2'b00};
  assign req_last     = {req_addr_i[31:2], 2'b11};
  assign misaligned   = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                        ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign out_of_range = (req_last >= LIMIT);
  assign illegal_size = (req_size_i == 2'b11);
  assign req_bad      = misaligned || out_of_range || illegal_size;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Lane extraction and extension for loads.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0: byte_sel = mem_data_i[7:0];
      2'd1: byte_sel = mem_data_i[15:8];
      2'd2: byte_sel = mem_data_i[23:16];
      default: byte_sel = mem_data_i[31:24];
    endcase
    half_sel = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    load_ext = mem_data_i;
    case (size_q)
      2'b00: load_ext = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01: load_ext = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_data_i;
    endcase
  end

  // Store lane(s) spliced into the word just read back.
  always_comb begin
    merged = mem_data_i;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'h0;
    resp_err_d   = 1'b0;
    mem_addr_d   = 32'h0;
    mem_data_d   = 32'h0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid_i) begin
          ready_d    = 1'b0;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          lane_d     = req_addr_i[1:0];
          wdata_d    = req_wdata_i[15:0];
          if (req_bad) begin
            state_d = ERR;
          end else if (!req_store_i) begin
            state_d    = LOAD;
            mem_read_d = 1'b1;
            mem_addr_d = req_word;
          end else if (req_size_i == 2'b10) begin
            state_d     = STWR;
            mem_write_d = 1'b1;
            mem_addr_d  = req_word;
            mem_data_d  = req_wdata_i;
          end else begin
            state_d    = RMWRD;
            mem_read_d = 1'b1;
            mem_addr_d = req_word;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = load_ext;
      end
      RMWRD: begin
        state_d     = RMWR;
        mem_write_d = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = merged;
      end
      RMWR, STWR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      ERR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Async reset also kills an in-flight write strobe before the next edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - directed vector bench for data_mem_master
// Holds a 32-word behavioural Data_Memory answering the master's port.
module tb_data_mem_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  always #5 clk_i = ~clk_i;

  data_mem_master #(.MEM_BYTES(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_store_i(req_store_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i)
  );

  logic [31:0] mem [0:31];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk_i) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_write_o) mem[mem_addr_o[6:2]] <= mem_data_o;
  end
  assign mem_data_i = mem[mem_addr_o[6:2]];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(negedge clk_i);
    pre_we  = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [4:0]  widx;
    logic [31:0] wexp;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic un,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] ed, input logic ee, input int lat,
                              input int rd, input int wr, input logic [4:0] widx,
                              input logic [31:0] wexp);
    vec_t v;
    v.st = st; v.sz = sz; v.un = un; v.addr = addr; v.wd = wd;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    v.widx = widx; v.wexp = wexp;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int i);
    int w;
    int lat;
    int rd;
    int wr;
    int bad;
    int badaddr;
    logic [31:0] rdata;
    logic rerr;
    w = 0;
    while (!req_ready_o && w < 10) begin
      @(negedge clk_i);
      w++;
    end
    check($sformatf("v%0d ready_before", i), {31'h0, req_ready_o}, 32'h1);
    req_valid_i = 1'b1; req_store_i = v.st; req_size_i = v.sz;
    req_unsigned_i = v.un; req_addr_i = v.addr; req_wdata_i = v.wd;
    lat = 0; rd = 0; wr = 0; bad = 0; badaddr = 0; rdata = 32'hx; rerr = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        check($sformatf("v%0d ready_busy", i), {31'h0, req_ready_o}, 32'h0);
        req_valid_i = 1'b0; req_store_i = ~v.st; req_size_i = 2'b00;
        req_unsigned_i = ~v.un; req_addr_i = 32'h0000_0044; req_wdata_i = 32'hFFFF_FFFF;
      end
      if (mem_read_o) rd++;
      if (mem_write_o) wr++;
      if (mem_read_o && mem_write_o) bad++;
      if (!mem_read_o && !mem_write_o && (mem_addr_o != 32'h0 || mem_data_o != 32'h0)) bad++;
      if ((mem_read_o || mem_write_o) && mem_addr_o !== {v.addr[31:2], 2'b00}) badaddr++;
      if (resp_valid_o) begin
        lat = k;
        rdata = resp_data_o;
        rerr = resp_err_o;
        break;
      end
    end
    check($sformatf("v%0d latency", i), lat, v.exp_lat);
    check($sformatf("v%0d resp_data", i), rdata, v.exp_data);
    check($sformatf("v%0d resp_err", i), {31'h0, rerr}, {31'h0, v.exp_err});
    check($sformatf("v%0d read_cycles", i), rd, v.exp_rd);
    check($sformatf("v%0d write_cycles", i), wr, v.exp_wr);
    check($sformatf("v%0d strobe_rule", i), bad, 0);
    check($sformatf("v%0d mem_addr", i), badaddr, 0);
    check($sformatf("v%0d mem_word", i), mem[v.widx], v.wexp);
    @(negedge clk_i);
    check($sformatf("v%0d resp_pulse", i), {31'h0, resp_valid_o}, 32'h0);
    check($sformatf("v%0d ready_after", i), {31'h0, req_ready_o}, 32'h1);
  endtask

  vec_t tbl[22];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int nr;
    int wrs;
    int rv;
    int acc[3];
    logic [31:0] hs_addr[3];
    logic [1:0]  hs_size[3];
    logic [31:0] hs_exp[3];

    rst_i = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    req_valid_i = 1'b0; req_store_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    @(negedge clk_i);
    check("rst ready", {31'h0, req_ready_o}, 32'h1);
    check("rst resp_valid", {31'h0, resp_valid_o}, 32'h0);
    check("rst resp_data", resp_data_o, 32'h0);
    check("rst resp_err", {31'h0, resp_err_o}, 32'h0);
    check("rst strobes", {30'h0, mem_read_o, mem_write_o}, 32'h0);
    check("rst mem_addr", mem_addr_o, 32'h0);
    check("rst mem_data", mem_data_o, 32'h0);
    preload(5'd1, 32'h8081_F0F1);
    preload(5'd2, 32'h5A5A_5A5A);
    preload(5'd4, 32'h1122_3344);
    preload(5'd8, 32'hCAFE_F00D);
    preload(5'd31, 32'h0000_0000);
    rst_i = 1'b0;
    @(negedge clk_i);

    //               st  sz     un  addr    wdata          exp_data       err lat rd wr widx wexp
    tbl[0]  = mk(0, 2'b00, 0, 32'h06, 32'h0,          32'hFFFF_FF81, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[1]  = mk(0, 2'b00, 1, 32'h06, 32'h0,          32'h0000_0081, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[2]  = mk(0, 2'b00, 0, 32'h05, 32'h0,          32'hFFFF_FFF0, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[3]  = mk(0, 2'b00, 1, 32'h04, 32'h0,          32'h0000_00F1, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[4]  = mk(0, 2'b00, 0, 32'h07, 32'h0,          32'hFFFF_FF80, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[5]  = mk(0, 2'b01, 0, 32'h06, 32'h0,          32'hFFFF_8081, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[6]  = mk(0, 2'b01, 1, 32'h06, 32'h0,          32'h0000_8081, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[7]  = mk(0, 2'b01, 0, 32'h04, 32'h0,          32'hFFFF_F0F1, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[8]  = mk(0, 2'b10, 1, 32'h04, 32'h0,          32'h8081_F0F1, 0, 2, 1, 0, 5'd1,  32'h8081_F0F1);
    tbl[9]  = mk(1, 2'b00, 0, 32'h12, 32'h1234_56AB,  32'h0,         0, 3, 1, 1, 5'd4,  32'h11AB_3344);
    tbl[10] = mk(1, 2'b01, 0, 32'h10, 32'hFFFF_CDEF,  32'h0,         0, 3, 1, 1, 5'd4,  32'h11AB_CDEF);
    tbl[11] = mk(1, 2'b10, 0, 32'h7C, 32'hDEAD_BEEF,  32'h0,         0, 2, 0, 1, 5'd31, 32'hDEAD_BEEF);
    tbl[12] = mk(0, 2'b00, 1, 32'h7F, 32'h0,          32'h0000_00DE, 0, 2, 1, 0, 5'd31, 32'hDEAD_BEEF);
    tbl[13] = mk(0, 2'b01, 0, 32'h7E, 32'h0,          32'hFFFF_DEAD, 0, 2, 1, 0, 5'd31, 32'hDEAD_BEEF);
    tbl[14] = mk(1, 2'b10, 0, 32'h80, 32'h1111_1111,  32'h0,         1, 2, 0, 0, 5'd31, 32'hDEAD_BEEF);
    tbl[15] = mk(0, 2'b01, 0, 32'h03, 32'h0,          32'h0,         1, 2, 0, 0, 5'd1,  32'h8081_F0F1);
    tbl[16] = mk(0, 2'b10, 0, 32'h06, 32'h0,          32'h0,         1, 2, 0, 0, 5'd1,  32'h8081_F0F1);
    tbl[17] = mk(0, 2'b11, 0, 32'h08, 32'h0,          32'h0,         1, 2, 0, 0, 5'd2,  32'h5A5A_5A5A);
    tbl[18] = mk(1, 2'b11, 0, 32'h08, 32'h0000_0000,  32'h0,         1, 2, 0, 0, 5'd2,  32'h5A5A_5A5A);
    tbl[19] = mk(0, 2'b00, 0, 32'h80, 32'h0,          32'h0,         1, 2, 0, 0, 5'd31, 32'hDEAD_BEEF);
    tbl[20] = mk(1, 2'b00, 0, 32'h7F, 32'h0000_0077,  32'h0,         0, 3, 1, 1, 5'd31, 32'h77AD_BEEF);
    tbl[21] = mk(1, 2'b01, 0, 32'h11, 32'h0000_9999,  32'h0,         1, 2, 0, 0, 5'd4,  32'h11AB_CDEF);

    for (int i = 0; i < 22; i++) apply_vec(tbl[i], i);

    // Three queued loads with req_valid_i held high.
    hs_addr[0] = 32'h04; hs_size[0] = 2'b10; hs_exp[0] = 32'h8081_F0F1;
    hs_addr[1] = 32'h12; hs_size[1] = 2'b01; hs_exp[1] = 32'h0000_11AB;
    hs_addr[2] = 32'h7C; hs_size[2] = 2'b00; hs_exp[2] = 32'h0000_00EF;
    idx = 0; nr = 0; wrs = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int c = 0; c < 40 && nr < 3; c++) begin
      @(negedge clk_i);
      if (mem_write_o) wrs++;
      if (resp_valid_o) begin
        if (nr < 3) check($sformatf("hs resp%0d", nr), resp_data_o, hs_exp[nr]);
        nr++;
      end
      if (req_ready_o && idx < 3) begin
        acc[idx] = c;
        req_valid_i = 1'b1; req_store_i = 1'b0; req_unsigned_i = 1'b1;
        req_size_i = hs_size[idx]; req_addr_i = hs_addr[idx]; req_wdata_i = 32'h0;
        idx++;
      end else begin
        req_valid_i = (idx < 3);
        req_store_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'hFFFF_FFFF;
      end
    end
    req_valid_i = 1'b0;
    check("hs responses", nr, 3);
    check("hs accept gap 0-1", acc[1] - acc[0], 3);
    check("hs accept gap 1-2", acc[2] - acc[1], 3);
    check("hs no writes", wrs, 0);
    check("hs mem0 intact", mem[0] === mem[0] ? mem[1] : 32'h0, 32'h8081_F0F1);

    // Reset asserted while the RMW write strobe is up.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_store_i = 1'b1; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = 32'h20; req_wdata_i = 32'h0000_0055;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("abort rmw read", {31'h0, mem_read_o}, 32'h1);
    @(negedge clk_i);
    check("abort rmw write", {31'h0, mem_write_o}, 32'h1);
    #1 rst_i = 1'b1;
    #1;
    check("abort write drop", {31'h0, mem_write_o}, 32'h0);
    check("abort ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk_i);
    rst_i = 1'b0;
    rv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) rv++;
    end
    check("abort no resp", rv, 0);
    check("abort idle ready", {31'h0, req_ready_o}, 32'h1);
    check("abort word intact", mem[8], 32'hCAFE_F00D);
    apply_vec(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 2, 1, 0, 5'd8, 32'hCAFE_F00D), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
